// File: rtl/input_debouncer_pkg.sv
// Shared types and defaults for the input debouncer: FSM state encoding and
// small state-decoding helpers used by the FSM output logic.
package debounce_pkg;

    localparam int DB_SYNC_STAGES_DEF = 2;
    localparam int DB_CYCLES_DEF      = 4;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b10,
        WAIT_LO   = 2'b11
    } db_state_t;

    // Level presented on d_out while the FSM sits in a given state.
    function automatic logic level_of(input db_state_t st);
        logic lvl;
        case (st)
            STABLE_LO: lvl = 1'b0;
            WAIT_HI:   lvl = 1'b0;
            STABLE_HI: lvl = 1'b1;
            WAIT_LO:   lvl = 1'b1;
            default:   lvl = 1'b0;
        endcase
        return lvl;
    endfunction

    function automatic logic is_wait(input db_state_t st);
        logic w;
        case (st)
            WAIT_HI: w = 1'b1;
            WAIT_LO: w = 1'b1;
            default: w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/input_debouncer_if.sv
// Signal bundle between the raw switch source and the debouncer outputs that
// feed the downstream D flip-flop stage.
interface input_debouncer_if;

    logic din;
    logic d_out;
    logic rise;
    logic fall;
    logic busy;

    modport master (
        output din,
        input  d_out,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  din,
        output d_out,
        output rise,
        output fall,
        output busy
    );

endinterface

// File: rtl/input_debouncer_chk.sv
// Output-relationship properties of the debouncer, kept apart from the design
// so they can be attached wherever the outputs are visible.
module input_debouncer_chk (
    input logic clk,
    input logic reset,
    input logic d_out,
    input logic rise,
    input logic fall,
    input logic busy
);

    a_rise_fall_excl: assert property (@(posedge clk) disable iff (!reset)
        !(rise && fall));

    a_rise_level: assert property (@(posedge clk) disable iff (!reset)
        rise |-> d_out);

    a_fall_level: assert property (@(posedge clk) disable iff (!reset)
        fall |-> !d_out);

    a_rise_single: assert property (@(posedge clk) disable iff (!reset)
        rise |=> !rise);

    a_fall_single: assert property (@(posedge clk) disable iff (!reset)
        fall |=> !fall);

    a_no_strobe_busy: assert property (@(posedge clk) disable iff (!reset)
        busy |-> (!rise && !fall));

endmodule

// File: rtl/input_debouncer_sync.sv
// Multi-flop synchronizer bringing the asynchronous raw input into the clk
// domain; q is d delayed by SYNC_STAGES flops.
module bit_synchronizer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = DB_SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift chain next-state: new sample enters at bit 0.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    // Synchronizer flops, cleared by the synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces a bouncy asynchronous input into a clean level with one-cycle
// rise/fall strobes; all outputs come straight from flops.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = DB_SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DB_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input_debouncer_if.slave   dbif
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic       s;
    db_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       d_out_q, d_out_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic       busy_q, busy_d;

    bit_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (dbif.din),
        .q     (s)
    );

    // Next-state, counter and strobe logic; any bounce back drops the partial count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (s) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = CNT_ZERO;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = CNT_ZERO;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = CNT_ZERO;
            end
        endcase
        d_out_d = level_of(state_d);
        busy_d  = is_wait(state_d);
    end

    // State, counter and registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= STABLE_LO;
            cnt_q   <= CNT_ZERO;
            d_out_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_out_q <= d_out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign dbif.d_out = d_out_q;
    assign dbif.rise  = rise_q;
    assign dbif.fall  = fall_q;
    assign dbif.busy  = busy_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed, table-driven bench for input_debouncer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_input_debouncer;
    import debounce_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    input_debouncer_if dbif ();

    input_debouncer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .dbif  (dbif)
    );

    input_debouncer_chk u_chk (
        .clk   (clk),
        .reset (reset),
        .d_out (dbif.d_out),
        .rise  (dbif.rise),
        .fall  (dbif.fall),
        .busy  (dbif.busy)
    );

    typedef struct {
        logic din;
        logic rst_n;
        logic d;
        logic r;
        logic f;
        logic b;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void add(input logic din, input logic rst_n,
                                input logic d, input logic r,
                                input logic f, input logic b);
        vec_t v;
        v.din = din; v.rst_n = rst_n; v.d = d; v.r = r; v.f = f; v.b = b;
        vecs.push_back(v);
    endfunction

    function automatic void add_rise7();
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic void add_fall7();
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic step(input logic din, input logic rst_n);
        dbif.din = din;
        reset    = rst_n;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    logic bdin [14];
    logic bbusy[14];
    logic rrst [12];
    logic rbusy[12];
    int   rises;
    int   latency;

    initial begin
        dbif.din = 1'b0;
        reset    = 1'b0;

        // Reset held three edges while din toggles.
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_rise7();
        add_fall7();

        // Bounce 1,1,1,0,1,1,0 then settle high.
        bdin  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        bbusy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 14; k++) begin
            add(bdin[k], 1'b1, (k >= 12) ? 1'b1 : 1'b0,
                (k == 12) ? 1'b1 : 1'b0, 1'b0, bbusy[k]);
        end
        add_fall7();

        // Reset pulse at E0+4 during qualification of a rising level.
        rrst  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        rbusy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 12; k++) begin
            add(1'b1, rrst[k], (k >= 10) ? 1'b1 : 1'b0,
                (k == 10) ? 1'b1 : 1'b0, 1'b0, rbusy[k]);
        end
        // Reset while high clears d_out without a fall strobe.
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].din, vecs[i].rst_n);
            chk($sformatf("vec%0d d_out", i), dbif.d_out, vecs[i].d);
            chk($sformatf("vec%0d rise",  i), dbif.rise,  vecs[i].r);
            chk($sformatf("vec%0d fall",  i), dbif.fall,  vecs[i].f);
            chk($sformatf("vec%0d busy",  i), dbif.busy,  vecs[i].b);
        end

        // Three-cycle high glitch from low must not reach d_out.
        rises = 0;
        for (int k = 0; k < 11; k++) begin
            step((k < 3) ? 1'b1 : 1'b0, 1'b1);
            if (dbif.rise === 1'b1) rises++;
            chk($sformatf("glitch_hi%0d d_out", k), dbif.d_out, 1'b0);
        end
        chk("glitch_hi rise_count", (rises == 0) ? 1'b1 : 1'b0, 1'b1);

        // Clean rise with bounded wait: d_out expected after the 6th edge.
        rises   = 0;
        latency = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b1);
            if (dbif.rise === 1'b1) rises++;
            if (latency == 0 && dbif.d_out === 1'b1) latency = k;
        end
        if (latency == 0) $display("FAIL rise_wait: timeout, d_out never rose in 20 edges");
        tests++;
        if (latency != 6) begin
            fails++;
            $display("FAIL rise_latency: got %0d edges expected 6", latency);
        end
        tests++;
        if (rises != 1) begin
            fails++;
            $display("FAIL rise_count: got %0d expected 1", rises);
        end

        // Three-cycle low glitch from high must not drop d_out.
        for (int k = 0; k < 11; k++) begin
            step((k < 3) ? 1'b0 : 1'b1, 1'b1);
            chk($sformatf("glitch_lo%0d d_out", k), dbif.d_out, 1'b1);
            chk($sformatf("glitch_lo%0d fall",  k), dbif.fall,  1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Conditions a raw, asynchronous, bouncy input (push-button or slide switch) into a clean single-bit level for the `d` input of the SR-built D flip-flop stage. It also produces one-cycle rise/fall strobes for that stage.
- A multi-flop synchronizer removes metastability.
- A 4-state FSM with a stability counter rejects bounce.
- Only a level held for `DEBOUNCE_CYCLES` consecutive synchronized samples reaches the output.

## Interface
- `SYNC_STAGES`, 2, synchronizer depth; legal ≥ 2.
- `DEBOUNCE_CYCLES`, 4, consecutive equal synchronized samples required to accept a new level; legal ≥ 2.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES+1)`, counter width; derived, do not override.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low: `reset==0` at a rising `clk` edge resets the block.
- `din`  in  1  raw asynchronous input; may glitch at any time.
- `d_out`  out  1  debounced level; drives the D flip-flop `d`.
- `rise`  out  1  one-cycle pulse in the cycle `d_out` goes 0→1.
- `fall`  out  1  one-cycle pulse in the cycle `d_out` goes 1→0.
- `busy`  out  1  high while in a WAIT state, i.e. a candidate change is being qualified.

## Operation
- Synchronizer output `s` is `din` delayed by `SYNC_STAGES` flops.
- FSM states and transitions:
  - STABLE_LO, `d_out`=0:
    - `s==1` → WAIT_HI, `cnt`=1.
    - else stay, `cnt`=0.
  - WAIT_HI:
    - `s==0` → STABLE_LO, `cnt`=0, no pulse.
    - `s==1` and `cnt==DEBOUNCE_CYCLES-1` → STABLE_HI, `d_out`=1, `rise`=1, `cnt`=0.
    - `s==1` otherwise → `cnt`+1.
  - STABLE_HI, `d_out`=1: mirror of STABLE_LO with `s==0` → WAIT_LO.
  - WAIT_LO: mirror of WAIT_HI; the exit to STABLE_LO sets `d_out`=0 and `fall`=1.
- `busy` is 1 exactly in WAIT_HI and WAIT_LO.
- `rise` and `fall` are never both 1, and each is 0 in every cycle other than the one after the accepting edge.
- `cnt` never exceeds `DEBOUNCE_CYCLES-1`; no wrap is possible.
- Any bounce back to the old level during WAIT restarts qualification from zero; a partial count is never retained.
- All outputs are registered; no combinational path from `din` to any output.

## Timing
- Reset values: synchronizer flops 0, state STABLE_LO, `cnt` 0, `d_out` 0, `rise` 0, `fall` 0, `busy` 0.
- Reset asserted mid-qualification aborts it: no pulse is emitted, and the pending level is lost.
- Reset has priority over all other activity in the same cycle.
- Latency: let E0 be the first rising edge at which `din` is sampled high, with `din` held high afterwards.
  - `s` becomes 1 after edge E0+`SYNC_STAGES`-1.
  - `d_out` and `rise` become 1 after edge E0+`SYNC_STAGES`+`DEBOUNCE_CYCLES`-1.
  - Defaults: visible after the 6th edge.
  - Falling direction is symmetric.
- `rise`/`fall` are high for exactly one cycle, coincident with the first cycle of the new `d_out` value.
- A `din` pulse or glitch lasting fewer than `DEBOUNCE_CYCLES` consecutive sampled cycles never changes `d_out`.
- The minimum spacing between two accepted changes is `DEBOUNCE_CYCLES` cycles.

## Structure
- Shared package `debounce_pkg`:
  - State enum `db_state_t` {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO}, 2 bits.
  - Default constants `DB_SYNC_STAGES_DEF`=2 and `DB_CYCLES_DEF`=4.
- One sub-module: `bit_synchronizer`, parameterized by `SYNC_STAGES`, with `clk`/`reset`/`d`/`q`. The FSM and counter stay in `input_debouncer`.

## Test plan
- Reset: hold `reset`=0 for 3 edges with `din` toggling every cycle → `d_out`=0, `rise`=0, `fall`=0, `busy`=0 on every edge.
- Clean rise: `din` 0→1 at E0 and held → `busy` goes 1 after edge E0+2; `d_out`=1 and a single-cycle `rise`=1 after edge E0+5.
- Bounce rejection: `din` pattern 1,1,1,0,1,1,0 (one value per cycle) → `d_out` stays 0, no `rise`, `busy` toggles.
- Bounce then settle: same pattern followed by 1 held → `d_out` rises 4 cycles after `s` last goes 1, with exactly one `rise`.
- Clean fall: from `d_out`=1, `din`→0 held → `d_out`=0 and a single `fall` after 6 edges; `rise` remains 0.
- Reset mid-qualification: `din`=1 held, `reset`=0 pulsed for one edge at E0+4 → no `rise` at E0+5. The count restarts from the reset, and `d_out`=1 only 6 edges after reset is released.
